seg_scan_bch_capture: RTL and testbench

- Captures a time-multiplexed NUM_DIGITS-digit 7-segment display bus (shared segment lines plus one-hot digit select) and converts it back to per-digit BCH codes.
- Each digit's value is de-glitched: a value is accepted only after STABLE_COUNT consecutive identical samples.
- Used by the self-check/readback path: watch and alarm display output is decoded back into numbers and compared against the internal time registers.
- Generalises the combinational segment-to-BCH inverse mapping with multiple channels, selectable segment polarity, stability filtering and error reporting.

---
 rtl/seg_scan_bch_capture_if.sv | 31 +++
 rtl/seg_scan_bch_capture.sv | 150 +++++++++++++++
 tb/tb_seg_scan_bch_capture.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_bch_capture_if.sv
// Bundles the display-bus capture signals.
//   master : drives sample_en, seg_in, digit_sel; receives decoded results
//   slave  : the capture block itself
//   sample_en   - qualifies seg_in/digit_sel this cycle
//   seg_in      - segments {a,b,c,d,e,f,g}, bit 6 = a
//   digit_sel   - one-hot digit enable
//   out_bch     - committed codes, digit i at [4i+3:4i]
//   digit_valid - digit i has committed at least once
//   update      - pulse on a committed value change / first commit
//   err         - pulse on bad pattern or non-one-hot select
interface seg_scan_bch_capture_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    sample_en;
   logic [6:0]              seg_in;
   logic [NUM_DIGITS-1:0]   digit_sel;
   logic [4*NUM_DIGITS-1:0] out_bch;
   logic [NUM_DIGITS-1:0]   digit_valid;
   logic                    update;
   logic                    err;

   modport master (
      output sample_en, seg_in, digit_sel,
      input  out_bch, digit_valid, update, err
   );

   modport slave (
      input  sample_en, seg_in, digit_sel,
      output out_bch, digit_valid, update, err
   );
endinterface

// File: rtl/seg_scan_bch_capture.sv
// Captures a multiplexed 7-segment display bus and turns it back into
// per-digit codes, committing a digit only after STABLE_COUNT identical
// consecutive samples of that digit.
//   clk - system clock
//   rst - synchronous active-high reset
//   bus - seg_scan_bch_capture_if slave (sample inputs, decoded outputs)
// Two-stage pipeline: stage 1 registers decode/select, stage 2 owns all
// per-digit candidate/count state so back-to-back samples of one digit
// always see up-to-date counters.
module seg_scan_bch_capture #(
   parameter int NUM_DIGITS     = 4,
   parameter int STABLE_COUNT   = 3,
   parameter int SEG_ACTIVE_LOW = 0
) (
   input logic                    clk,
   input logic                    rst,
   seg_scan_bch_capture_if.slave  bus
);
   localparam int         IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [3:0] SAT   = 4'(STABLE_COUNT);

   logic [6:0]       seg_eff;
   logic [3:0]       code_d;
   logic [IDX_W-1:0] idx_d;
   logic             onehot_d;

   logic             s1_valid_q;
   logic [3:0]       s1_code_q;
   logic [IDX_W-1:0] s1_idx_q;
   logic             s1_ok_q;

   logic [3:0]            cand_q  [NUM_DIGITS];
   logic [3:0]            cand_d  [NUM_DIGITS];
   logic [3:0]            cnt_q   [NUM_DIGITS];
   logic [3:0]            cnt_d   [NUM_DIGITS];
   logic [3:0]            out_q   [NUM_DIGITS];
   logic [3:0]            out_d   [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] valid_q, valid_d;
   logic                  update_q, update_d;
   logic                  err_q, err_d;
   logic [3:0]            new_cnt;

   assign seg_eff = (SEG_ACTIVE_LOW != 0) ? ~bus.seg_in : bus.seg_in;

   always_comb begin
      case (seg_eff)
         7'b1111110: code_d = 4'd0;
         7'b0110000: code_d = 4'd1;
         7'b1101101: code_d = 4'd2;
         7'b1111001: code_d = 4'd3;
         7'b0110011: code_d = 4'd4;
         7'b1011011: code_d = 4'd5;
         7'b1011111: code_d = 4'd6;
         7'b1110000: code_d = 4'd7;
         7'b1111111: code_d = 4'd8;
         7'b1111011: code_d = 4'd9;
         7'b0000001: code_d = 4'd10;
         default:    code_d = 4'hF;
      endcase
   end

   // OR-encoder; the index is only trusted when the select is one-hot.
   always_comb begin
      idx_d = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bus.digit_sel[i]) idx_d = idx_d | IDX_W'(i);
      end
   end

   assign onehot_d = $onehot(bus.digit_sel);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_code_q  <= 4'hF;
         s1_idx_q   <= '0;
         s1_ok_q    <= 1'b0;
      end else begin
         s1_valid_q <= bus.sample_en;
         s1_code_q  <= code_d;
         s1_idx_q   <= idx_d;
         s1_ok_q    <= onehot_d;
      end
   end

   always_comb begin
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      out_d    = out_q;
      valid_d  = valid_q;
      update_d = 1'b0;
      err_d    = 1'b0;
      new_cnt  = 4'd0;
      if (s1_valid_q) begin
         if (!s1_ok_q) begin
            err_d = 1'b1;
         end else if (s1_code_q == 4'hF) begin
            // Invalid pattern breaks the run but leaves the committed value alone.
            err_d            = 1'b1;
            cand_d[s1_idx_q] = 4'hF;
            cnt_d[s1_idx_q]  = 4'd0;
         end else begin
            if (s1_code_q == cand_q[s1_idx_q])
               new_cnt = (cnt_q[s1_idx_q] >= SAT) ? SAT : cnt_q[s1_idx_q] + 4'd1;
            else
               new_cnt = 4'd1;
            cand_d[s1_idx_q] = s1_code_q;
            cnt_d[s1_idx_q]  = new_cnt;
            if (new_cnt == SAT) begin
               if (!valid_q[s1_idx_q] || (out_q[s1_idx_q] != s1_code_q))
                  update_d = 1'b1;
               out_d[s1_idx_q]   = s1_code_q;
               valid_d[s1_idx_q] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            cand_q[i] <= 4'hF;
            cnt_q[i]  <= 4'd0;
            out_q[i]  <= 4'd0;
         end
         valid_q  <= '0;
         update_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         out_q    <= out_d;
         valid_q  <= valid_d;
         update_q <= update_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      bus.out_bch = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         bus.out_bch[4*i +: 4] = out_q[i];
      end
   end

   assign bus.digit_valid = valid_q;
   assign bus.update      = update_q;
   assign bus.err         = err_q;

endmodule

// File: tb/tb_seg_scan_bch_capture.sv
module tb_seg_scan_bch_capture;
   localparam logic [6:0] SEG_0    = 7'b1111110;
   localparam logic [6:0] SEG_1    = 7'b0110000;
   localparam logic [6:0] SEG_4    = 7'b0110011;
   localparam logic [6:0] SEG_5    = 7'b1011011;
   localparam logic [6:0] SEG_8    = 7'b1111111;
   localparam logic [6:0] SEG_DASH = 7'b0000001;
   localparam logic [6:0] SEG_BAD  = 7'b1000000;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_pass;

   seg_scan_bch_capture_if #(.NUM_DIGITS(4)) bus_a ();
   seg_scan_bch_capture_if #(.NUM_DIGITS(4)) bus_b ();

   seg_scan_bch_capture #(
      .NUM_DIGITS(4), .STABLE_COUNT(3), .SEG_ACTIVE_LOW(0)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   seg_scan_bch_capture #(
      .NUM_DIGITS(4), .STABLE_COUNT(3), .SEG_ACTIVE_LOW(1)
   ) u_dut_al (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   // Each step lands on a falling edge; outputs seen right after a step
   // reflect the sample driven two steps earlier.
   task automatic step_a(input logic en, input logic [3:0] sel, input logic [6:0] seg);
      @(negedge clk);
      bus_a.sample_en = en;
      bus_a.digit_sel = sel;
      bus_a.seg_in    = seg;
   endtask

   task automatic step_b(input logic en, input logic [3:0] sel, input logic [6:0] seg);
      @(negedge clk);
      bus_b.sample_en = en;
      bus_b.digit_sel = sel;
      bus_b.seg_in    = seg;
   endtask

   task automatic idle();
      step_a(1'b0, 4'b0000, 7'b0000000);
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      rst    = 1'b1;
      bus_a.sample_en = 1'b0; bus_a.digit_sel = '0; bus_a.seg_in = '0;
      bus_b.sample_en = 1'b0; bus_b.digit_sel = '0; bus_b.seg_in = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      chk("rst_out",    32'(bus_a.out_bch), 32'h0000);
      chk("rst_valid",  32'(bus_a.digit_valid), 32'h0);
      chk("rst_update", 32'(bus_a.update), 32'h0);
      chk("rst_err",    32'(bus_a.err), 32'h0);

      // digit 0 <- 1
      for (int i = 0; i < 3; i++) step_a(1'b1, 4'b0001, SEG_1);
      idle();
      chk("d0_two_valid",  32'(bus_a.digit_valid), 32'h0);
      chk("d0_two_update", 32'(bus_a.update), 32'h0);
      idle();
      chk("d0_out",    32'(bus_a.out_bch), 32'h0001);
      chk("d0_valid",  32'(bus_a.digit_valid), 32'h1);
      chk("d0_update", 32'(bus_a.update), 32'h1);
      idle();
      chk("d0_upd_pulse", 32'(bus_a.update), 32'h0);

      // digit 2: 5,5,8,8,8
      step_a(1'b1, 4'b0100, SEG_5);
      step_a(1'b1, 4'b0100, SEG_5);
      step_a(1'b1, 4'b0100, SEG_8);
      step_a(1'b1, 4'b0100, SEG_8);
      chk("d2_no5_valid", 32'(bus_a.digit_valid), 32'h1);
      step_a(1'b1, 4'b0100, SEG_8);
      chk("d2_no5_upd", 32'(bus_a.update), 32'h0);
      idle();
      chk("d2_pre_out", 32'(bus_a.out_bch), 32'h0001);
      idle();
      chk("d2_out",    32'(bus_a.out_bch), 32'h0801);
      chk("d2_valid",  32'(bus_a.digit_valid), 32'h5);
      chk("d2_update", 32'(bus_a.update), 32'h1);

      // digit 1 <- 4, then glitch
      for (int i = 0; i < 3; i++) step_a(1'b1, 4'b0010, SEG_4);
      idle();
      idle();
      chk("d1_out",    32'(bus_a.out_bch), 32'h0841);
      chk("d1_update", 32'(bus_a.update), 32'h1);
      step_a(1'b1, 4'b0010, SEG_BAD);
      idle();
      chk("gl_err_early", 32'(bus_a.err), 32'h0);
      idle();
      chk("gl_err",   32'(bus_a.err), 32'h1);
      chk("gl_out",   32'(bus_a.out_bch), 32'h0841);
      chk("gl_valid", 32'(bus_a.digit_valid), 32'h7);
      step_a(1'b1, 4'b0010, SEG_4);
      chk("gl_err_pulse", 32'(bus_a.err), 32'h0);
      step_a(1'b1, 4'b0010, SEG_4);
      idle();
      chk("gl_re1_upd", 32'(bus_a.update), 32'h0);
      idle();
      chk("gl_re2_upd", 32'(bus_a.update), 32'h0);
      chk("gl_re_out",  32'(bus_a.out_bch), 32'h0841);

      // non-one-hot selects
      step_a(1'b1, 4'b0110, SEG_8);
      idle();
      idle();
      chk("sel2_err", 32'(bus_a.err), 32'h1);
      chk("sel2_out", 32'(bus_a.out_bch), 32'h0841);
      step_a(1'b1, 4'b0000, SEG_8);
      idle();
      idle();
      chk("sel0_err",   32'(bus_a.err), 32'h1);
      chk("sel0_valid", 32'(bus_a.digit_valid), 32'h7);
      chk("sel0_upd",   32'(bus_a.update), 32'h0);

      // digit 3 <- dash
      for (int i = 0; i < 3; i++) step_a(1'b1, 4'b1000, SEG_DASH);
      idle();
      idle();
      chk("d3_out",   32'(bus_a.out_bch), 32'hA841);
      chk("d3_valid", 32'(bus_a.digit_valid), 32'hF);

      // digit 0 changes 1 -> 0 interleaved with digit 2 samples
      step_a(1'b1, 4'b0001, SEG_0);
      step_a(1'b1, 4'b0100, SEG_8);
      step_a(1'b1, 4'b0001, SEG_0);
      step_a(1'b1, 4'b0100, SEG_8);
      step_a(1'b1, 4'b0001, SEG_0);
      idle();
      chk("il_upd_sat", 32'(bus_a.update), 32'h0);
      idle();
      chk("il_out", 32'(bus_a.out_bch), 32'hA840);
      chk("il_upd", 32'(bus_a.update), 32'h1);

      // active-low instance: inverted dash reads as 0
      for (int i = 0; i < 3; i++) step_b(1'b1, 4'b0001, SEG_DASH);
      step_b(1'b0, 4'b0000, 7'b0000000);
      step_b(1'b0, 4'b0000, 7'b0000000);
      chk("al_out",   32'(bus_b.out_bch), 32'h0000);
      chk("al_valid", 32'(bus_b.digit_valid), 32'h1);
      chk("al_upd",   32'(bus_b.update), 32'h1);
      chk("al_err",   32'(bus_b.err), 32'h0);

      // reset with a committing sample in flight
      for (int i = 0; i < 3; i++) step_a(1'b1, 4'b0001, SEG_5);
      @(negedge clk);
      bus_a.sample_en = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("ifr_out",    32'(bus_a.out_bch), 32'h0000);
      chk("ifr_valid",  32'(bus_a.digit_valid), 32'h0);
      chk("ifr_update", 32'(bus_a.update), 32'h0);
      idle();
      chk("ifr_update2", 32'(bus_a.update), 32'h0);
      chk("ifr_out2",    32'(bus_a.out_bch), 32'h0000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
